sliced_subtractor64: RTL and testbench
======================================

Name: sliced_subtractor64

Overview:
- Multi-cycle 64-bit subtractor; the inverse operation of the team's 64-bit ripple adder chain.
- Computes diff = a - b - bin by reusing a single SLICE-bit add slice over WIDTH/SLICE cycles.
- Each slice adds a, the one's complement of b, and a carry; the carry is registered between slices.
- Serves datapaths that need subtraction or compare with a small area and fixed latency, under a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand and result width. Must be a multiple of SLICE.
- SLICE, 16, bits processed per cycle.
- NSLICE, WIDTH/SLICE (4), derived. Not overridden by instantiators.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend. Bit 0 is the LSB (ascending [0:WIDTH-1] vectors, as in the adder chain).
- b  input  WIDTH  subtrahend, same bit ordering as a.
- bin  input  1  borrow in.
- diff  output  WIDTH  result, bit 0 is the LSB.
- bout  output  1  borrow out: 1 when unsigned a < b + bin.
- ovf  output  1  signed overflow of a - b - bin.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff, bout and ovf are valid.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, slice index=0, diff=0, bout=0, ovf=0, busy=0, done=0. rst has priority over every other input, including mid-operation; a partial result is discarded.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1, capture a, b and bin into internal registers.
  - Set carry = ~bin, slice index = 0, busy = 1, go to RUN.
  - When start=0, stay in IDLE.
- RUN, each cycle:
  - Compute slice k (bits k*SLICE .. k*SLICE+SLICE-1) as a_k + ~b_k + carry.
  - Write the sum into diff bits of slice k and register the slice carry-out as carry.
  - If k = NSLICE-1, go to FIN; otherwise increment k.
- FIN, one cycle:
  - bout = ~carry.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - done = 1 for this cycle only, busy = 0, return to IDLE.
- Latency: start is sampled at edge E; done is high in the cycle after edge E+NSLICE+1 (6 edges after sampling for the defaults). Throughput is one operation per NSLICE+2 cycles.
- Result width: diff = (a - b - bin) mod 2^WIDTH. There is no saturation.
- Output holding: diff, bout and ovf hold their values from the done cycle until the next accepted start. During RUN, diff is partially updated and is not valid.
- Input stability: a, b and bin may change freely after the start cycle because they are captured.
- start while busy=1, or in the FIN cycle: ignored, not queued.
- start in the same cycle as rst: reset wins and the request is lost.
- start held high continuously: a new operation begins in the IDLE cycle after each done. Outputs remain stable through that IDLE cycle.
- done and busy are never high in the same cycle.

Test Plan:
- Reset check: assert rst for 2 cycles with start=1 -> diff=0, bout=0, ovf=0, busy=0, done=0; no operation starts.
- Basic subtract: a=100, b=58, bin=0 -> done after 6 edges; diff=42, bout=0, ovf=0; busy high for exactly 5 cycles before done.
- Wrap-around with inter-slice borrow: a=0x0000_0001_0000_0000, b=1, bin=0 -> diff=0x0000_0000_FFFF_FFFF, bout=0. Then a=0, b=0, bin=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1.
- Signed overflow: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0. Then a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, ovf=1, bout=1.
- Handshake misuse: start op1 (a=10, b=3), pulse start with a=99 during RUN, and change the a/b inputs mid-op -> single done with diff=7; no second done.
- Reset mid-operation: start a=5, b=9, assert rst at the 2nd RUN cycle, then start a=9, b=5 -> no done for the first op; second op gives diff=4, bout=0 with the full 6-edge latency.

Source files
------------

// File: rtl/sliced_subtractor64.sv
// Multi-cycle subtractor: diff = a - b - bin, computed SLICE bits per cycle by a
// single adder slice (a + ~b + carry) with the carry registered between slices.
module sliced_subtractor64 #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SLICE  = 16,
    parameter int unsigned NSLICE = WIDTH / SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             bin,
    output logic [0:WIDTH-1] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_carry;
    logic [KW-1:0]        r_k;
    logic                 r_bout;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [SLICE-1:0]     w_a_sl;
    logic [SLICE-1:0]     w_b_sl;
    logic [SLICE:0]       w_sum;
    logic                 w_last;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // Ports use ascending ranges with index 0 as LSB; internally everything is
    // held in descending order so arithmetic and part-selects read naturally.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_a[i] = a[i];
            w_b[i] = b[i];
        end
    end

    always_comb begin
        diff = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff[i] = r_diff[i];
        end
    end

    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

    // Slice operand select
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (r_k == KW'(s)) begin
                w_a_sl = r_a[s*SLICE +: SLICE];
                w_b_sl = r_b[s*SLICE +: SLICE];
            end
        end
    end

    assign w_sum  = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_last = (r_k == KW'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy/done are registered, so their next values are decoded here and
    // land one edge later; done therefore appears in the IDLE cycle after FIN.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        unique case (r_state)
            S_IDLE:  w_busy_nxt = start;
            S_RUN:   w_busy_nxt = 1'b1;
            S_FIN:   w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_carry <= ~bin;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    for (int unsigned s = 0; s < NSLICE; s++) begin
                        if (r_k == KW'(s)) begin
                            r_diff[s*SLICE +: SLICE] <= w_sum[SLICE-1:0];
                        end
                    end
                    r_carry <= w_sum[SLICE];
                    if (!w_last) begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_FIN: begin
                    r_bout <= ~r_carry;
                    r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                              (r_diff[WIDTH-1] != r_a[WIDTH-1]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sliced_subtractor64.sv
// Randomized self-checking bench for sliced_subtractor64 against a plain
// 64-bit arithmetic reference model.
module tb_sliced_subtractor64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [0:63] a;
    logic [0:63] b;
    logic        bin;
    logic [0:63] diff;
    logic        bout;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    sliced_subtractor64 #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Port vectors are [0:63] with index 0 as LSB; map to numeric values by index.
    function automatic logic [0:63] to_port(input logic [63:0] v);
        logic [0:63] p;
        for (int i = 0; i < 64; i++) p[i] = v[i];
        return p;
    endfunction

    function automatic logic [63:0] from_port(input logic [0:63] p);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = p[i];
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full operation: checks latency, busy length, results, hold and done width.
    task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, input string tag);
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        int          edges;
        int          busy_cyc;
        bit          seen;
        bit          overlap;
        ed = av - bv - {63'd0, bi};
        eb = ({1'b0, av} < ({1'b0, bv} + {64'd0, bi}));
        eo = (av[63] != bv[63]) && (ed[63] != av[63]);
        @(negedge clk);
        a = to_port(av); b = to_port(bv); bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = to_port(rnd64()); b = to_port(rnd64()); bin = ~bi;
        edges = 1; busy_cyc = busy ? 1 : 0; seen = 0; overlap = (busy && done);
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (busy && done) overlap = 1;
            if (done) seen = 1;
            else if (busy) busy_cyc++;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL %s timeout: no done within %0d edges", tag, edges); end
        n_cmp++;
        if (edges !== 6) begin n_bad++; $display("FAIL %s latency: got %0d edges, want 6", tag, edges); end
        n_cmp++;
        if (busy_cyc !== 5) begin n_bad++; $display("FAIL %s busy_cycles: got %0d, want 5", tag, busy_cyc); end
        n_cmp++;
        if (overlap) begin n_bad++; $display("FAIL %s busy_done_overlap: got 1, want 0", tag); end
        n_cmp++;
        if (from_port(diff) !== ed) begin n_bad++; $display("FAIL %s diff: got %h, want %h", tag, from_port(diff), ed); end
        n_cmp++;
        if (bout !== eb) begin n_bad++; $display("FAIL %s bout: got %b, want %b", tag, bout, eb); end
        n_cmp++;
        if (ovf !== eo) begin n_bad++; $display("FAIL %s ovf: got %b, want %b", tag, ovf, eo); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL %s done_pulse: got %b, want 0", tag, done); end
        n_cmp++;
        if (from_port(diff) !== ed || bout !== eb || ovf !== eo) begin
            n_bad++; $display("FAIL %s hold: got %h/%b/%b, want %h/%b/%b", tag, from_port(diff), bout, ovf, ed, eb, eo);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = to_port(rnd64()); b = to_port(rnd64()); bin = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (from_port(diff) !== 64'd0 || bout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++; $display("FAIL reset_state: diff=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
                                  from_port(diff), bout, ovf, busy, done);
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_start: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_directed();
        do_op(64'd100, 64'd58, 1'b0, "basic");
        do_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, "wrap_borrow");
        do_op(64'd0, 64'd0, 1'b1, "zero_bin");
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, "ovf_neg");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "ovf_pos");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "all_ones_bin");
    endtask

    task automatic test_random();
        logic [63:0] av;
        logic [63:0] bv;
        for (int i = 0; i < 40; i++) begin
            av = rnd64();
            bv = (i % 8 == 0) ? av : rnd64();
            if (i % 5 == 1) bv[15:0] = av[15:0];
            do_op(av, bv, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_misuse();
        int edges;
        int ndone;
        @(negedge clk);
        a = to_port(64'd10); b = to_port(64'd3); bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = to_port(64'd99);
        @(negedge clk);
        start = 1'b0; b = to_port(64'd50);
        edges = 0; ndone = 0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                ndone++;
                n_cmp++;
                if (from_port(diff) !== 64'd7) begin
                    n_bad++; $display("FAIL misuse_diff: got %h, want %h", from_port(diff), 64'd7);
                end
            end
        end
        n_cmp++;
        if (ndone !== 1) begin n_bad++; $display("FAIL misuse_done_count: got %0d, want 1", ndone); end
    endtask

    task automatic test_reset_mid_op();
        int edges;
        bit seen;
        @(negedge clk);
        a = to_port(64'd5); b = to_port(64'd9); bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || from_port(diff) !== 64'd0) begin
            n_bad++; $display("FAIL midrst_state: busy=%b done=%b diff=%h, want 0/0/0", busy, done, from_port(diff));
        end
        edges = 0; seen = 0;
        while (edges < 10) begin
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL midrst_stale_done: got 1, want 0"); end
        do_op(64'd9, 64'd5, 1'b0, "after_midrst");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1;
        logic [63:0] b1;
        logic [63:0] a2;
        logic [63:0] b2;
        int          edges;
        int          done_at[$];
        logic [63:0] got[$];
        a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
        @(negedge clk);
        a = to_port(a1); b = to_port(b1); bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = to_port(a2); b = to_port(b2);
        edges = 1;
        while (done_at.size() < 2 && edges < 30) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin done_at.push_back(edges); got.push_back(from_port(diff)); end
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done_at.size() !== 2) begin
            n_bad++; $display("FAIL b2b_done_count: got %0d, want 2", done_at.size());
        end else begin
            n_cmp++;
            if (done_at[1] - done_at[0] !== 6) begin
                n_bad++; $display("FAIL b2b_period: got %0d, want 6", done_at[1] - done_at[0]);
            end
            n_cmp++;
            if (got[0] !== a1 - b1) begin n_bad++; $display("FAIL b2b_first: got %h, want %h", got[0], a1 - b1); end
            n_cmp++;
            if (got[1] !== a2 - b2) begin n_bad++; $display("FAIL b2b_second: got %h, want %h", got[1], a2 - b2); end
        end
        repeat (8) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_random();
        test_misuse();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
